// File: rtl/phi_clock_pkg.sv
// -----------------------------------------------------------------------------
// phi_clock_pkg
// Shared types and constants for the phi1/phi2 non-overlapping clock generator.
//   state_t          : sequencer states, visited S_PHI1 -> S_GAP1 -> S_PHI2 -> S_GAP2
//   PHI1_RST/PHI2_RST: phase levels forced while reset is asserted
//   RDY_RST          : reset level of the RDY synchronizer and of rdy_cpu
//   ph_cnt_width()   : phase-counter width for a given phase/dead-time setting
// -----------------------------------------------------------------------------
package phi_clock_pkg;

    typedef enum logic [1:0] {
        S_PHI1 = 2'd0,
        S_GAP1 = 2'd1,
        S_PHI2 = 2'd2,
        S_GAP2 = 2'd3
    } state_t;

    // Reset leaves phi1 high and phi2 low so the socket never sees both high.
    localparam logic PHI1_RST = 1'b1;
    localparam logic PHI2_RST = 1'b0;
    localparam logic RDY_RST  = 1'b1;

    // The phase counter must hold values up to max(PHASE_CYCLES, DEAD_CYCLES)-1.
    function automatic int ph_cnt_width(input int phase_cycles, input int dead_cycles);
        int span;
        span = (phase_cycles > dead_cycles) ? phase_cycles : dead_cycles;
        return (span < 2) ? 1 : $clog2(span);
    endfunction

endpackage

// File: rtl/phi_clock_gen_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous level.
//   clock     : destination clock
//   reset     : asynchronous, active-high; both flops load RESET_VAL
//   i_d       : asynchronous input level
//   o_q       : synchronized level, two clock edges behind i_d
// -----------------------------------------------------------------------------
module sync2
    import phi_clock_pkg::*;
#(
    parameter logic RESET_VAL = RDY_RST
) (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/phi_clock_gen.sv
// -----------------------------------------------------------------------------
// phi_clock_gen
// Non-overlapping phi1/phi2 clock pair for the 6509 socket, derived from one
// fast master clock, with phi1 stretch/halt, phi1-aligned RDY and edge strobes.
//   clock       : master clock, all state updates on the rising edge
//   reset       : asynchronous, active-high
//   enable      : 0 freezes the sequencer, counter and rdy_cpu
//   stretch     : extend phi1-high while 1 at the last phi1 count
//   halt        : freeze in phi1-high while 1 at the last phi1 count
//   rdy_in      : asynchronous external RDY
//   phi1, phi2  : phase clocks (registered, never both high)
//   phi2_rise   : 1 in the first phi2-high cycle
//   phi2_fall   : 1 in the first cycle after phi2 drops
//   rdy_cpu     : synchronized RDY, updated only on entry to phi1-high
//   cycle_count : completed phi2 phases, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module phi_clock_gen
    import phi_clock_pkg::*;
#(
    parameter int PHASE_CYCLES = 8,
    parameter int DEAD_CYCLES  = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             stretch,
    input  logic             halt,
    input  logic             rdy_in,
    output logic             phi1,
    output logic             phi2,
    output logic             phi2_rise,
    output logic             phi2_fall,
    output logic             rdy_cpu,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int             PH_W       = ph_cnt_width(PHASE_CYCLES, DEAD_CYCLES);
    localparam logic [PH_W-1:0] PHASE_LAST = PH_W'(PHASE_CYCLES - 1);
    localparam logic [PH_W-1:0] DEAD_LAST  = PH_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [PH_W-1:0] PH_ONE     = PH_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    // With no dead time the gap states are never entered.
    localparam bit              HAS_GAP    = (DEAD_CYCLES > 0);

    state_t            r_state;
    state_t            w_state_next;
    logic [PH_W-1:0]   r_cnt;
    logic [PH_W-1:0]   w_cnt_next;
    logic              w_rdy_sync;
    logic              w_enter_phi1;
    logic              w_rise_next;
    logic              w_fall_next;

    logic              r_phi1;
    logic              r_phi2;
    logic              r_phi2_rise;
    logic              r_phi2_fall;
    logic              r_rdy_cpu;
    logic [CNT_W-1:0]  r_cycle_count;

    sync2 #(
        .RESET_VAL (RDY_RST)
    ) u_rdy_sync (
        .clock (clock),
        .reset (reset),
        .i_d   (rdy_in),
        .o_q   (w_rdy_sync)
    );

    // Next-state and next-count logic. With enable low both hold, which also
    // suppresses every transition-derived strobe below.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (enable) begin
            unique case (r_state)
                S_PHI1: begin
                    if (r_cnt != PHASE_LAST) begin
                        w_cnt_next = r_cnt + PH_ONE;
                    end else if (!(stretch || halt)) begin
                        // At the last count, a pending stretch or halt holds
                        // phi1 high with the counter parked at its final value.
                        w_state_next = HAS_GAP ? S_GAP1 : S_PHI2;
                        w_cnt_next   = '0;
                    end
                end
                S_GAP1: begin
                    if (r_cnt != DEAD_LAST) begin
                        w_cnt_next = r_cnt + PH_ONE;
                    end else begin
                        w_state_next = S_PHI2;
                        w_cnt_next   = '0;
                    end
                end
                S_PHI2: begin
                    if (r_cnt != PHASE_LAST) begin
                        w_cnt_next = r_cnt + PH_ONE;
                    end else begin
                        w_state_next = HAS_GAP ? S_GAP2 : S_PHI1;
                        w_cnt_next   = '0;
                    end
                end
                S_GAP2: begin
                    if (r_cnt != DEAD_LAST) begin
                        w_cnt_next = r_cnt + PH_ONE;
                    end else begin
                        w_state_next = S_PHI1;
                        w_cnt_next   = '0;
                    end
                end
                default: begin
                    w_state_next = S_PHI1;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    assign w_enter_phi1 = (w_state_next == S_PHI1) && (r_state != S_PHI1);
    assign w_rise_next  = (w_state_next == S_PHI2) && (r_state != S_PHI2);
    assign w_fall_next  = (r_state == S_PHI2) && (w_state_next != S_PHI2);

    // Outputs are registered from the next state so each output flop changes
    // on the same edge as the state it reflects.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_PHI1;
            r_cnt         <= '0;
            r_phi1        <= PHI1_RST;
            r_phi2        <= PHI2_RST;
            r_phi2_rise   <= 1'b0;
            r_phi2_fall   <= 1'b0;
            r_rdy_cpu     <= RDY_RST;
            r_cycle_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_phi1      <= (w_state_next == S_PHI1);
            r_phi2      <= (w_state_next == S_PHI2);
            r_phi2_rise <= w_rise_next;
            r_phi2_fall <= w_fall_next;
            // RDY only moves at phi1-high entry, so it is stable across phi2.
            if (w_enter_phi1) begin
                r_rdy_cpu <= w_rdy_sync;
            end
            if (w_fall_next) begin
                r_cycle_count <= r_cycle_count + CNT_ONE;
            end
        end
    end

    assign phi1        = r_phi1;
    assign phi2        = r_phi2;
    assign phi2_rise   = r_phi2_rise;
    assign phi2_fall   = r_phi2_fall;
    assign rdy_cpu     = r_rdy_cpu;
    assign cycle_count = r_cycle_count;

endmodule
